// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its RAM.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Byte offset from the memory base; wraps as 32-bit unsigned.
  function automatic logic [WORD_W-1:0] byte_offset(input logic [WORD_W-1:0] addr,
                                                    input logic [WORD_W-1:0] base);
    return addr - base;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with a registered read port (read-before-write).
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Word-addressed data-memory responder with fixed wait states and a one-cycle ready strobe.
// Optional fault checking (misaligned / out-of-range) is enabled by defining DMEM_ERR_CHECK_EN.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [WORD_W-1:0] dAddress,
  input  logic [WORD_W-1:0] dWriteData,
  output logic [WORD_W-1:0] dReadData,
  output logic              mem_ready,
  output logic              mem_err
);

  localparam int              AW        = $clog2(DEPTH_WORDS);
  localparam bit              NO_WAIT   = (WAIT_CYCLES == 0);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? WAIT_W'(WAIT_CYCLES - 1) : '0;

  state_t            state;
  logic [WAIT_W-1:0] cnt;
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              wr_q;
  logic              ready_q;
  logic              show_ram;
  logic [WORD_W-1:0] hold;

  logic              req;
  logic              enter_resp;
  logic [WORD_W-1:0] cur_addr;
  logic [WORD_W-1:0] cur_wdata;
  logic              cur_wr;
  logic              fault;
  logic              we;
  logic [AW-1:0]     ram_addr;
  logic [WORD_W-1:0] rdata;

  // With zero wait states the access commits on the accept edge itself, so the
  // RAM is fed straight from the request inputs while idle.
  always_comb begin
    req        = MemRead | MemWrite;
    cur_addr   = (state == IDLE) ? dAddress   : addr_q;
    cur_wdata  = (state == IDLE) ? dWriteData : wdata_q;
    cur_wr     = (state == IDLE) ? MemWrite   : wr_q;
    enter_resp = ((state == IDLE) && req && NO_WAIT) || ((state == WAIT) && (cnt == '0));
    ram_addr   = AW'(byte_offset(cur_addr, BASE_ADDR) >> 2);
`ifdef DMEM_ERR_CHECK_EN
    fault      = (cur_addr[1:0] != 2'b00) ||
                 ((byte_offset(cur_addr, BASE_ADDR) >> 2) >= WORD_W'(DEPTH_WORDS));
`else
    fault      = 1'b0;
`endif
    we         = !rst && enter_resp && cur_wr && !fault;
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .we   (we),
    .addr (ram_addr),
    .wdata(cur_wdata),
    .rdata(rdata)
  );

  always_ff @(posedge clk) begin
    if ((state == IDLE) && req) begin
      addr_q  <= dAddress;
      wdata_q <= dWriteData;
      wr_q    <= MemWrite;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ready_q  <= 1'b0;
      show_ram <= 1'b0;
      hold     <= '0;
    end else begin
      ready_q  <= 1'b0;
      show_ram <= 1'b0;
      if (show_ram) hold <= rdata;
      case (state)
        IDLE: if (req) begin
          state <= NO_WAIT ? RESP : WAIT;
          cnt   <= WAIT_LOAD;
        end
        WAIT: if (cnt == '0) state <= RESP;
              else           cnt   <= cnt - 1'b1;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // The RAM's registered output carries a good read during RESP; afterwards
      // the captured copy keeps it stable until the next read completes.
      if (enter_resp) begin
        ready_q <= 1'b1;
        if (!cur_wr) begin
          if (fault) hold     <= '0;
          else       show_ram <= 1'b1;
        end
      end
    end
  end

`ifdef DMEM_ERR_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= enter_resp && fault;
  end
  assign mem_err = err_q;
`else
  assign mem_err = 1'b0;
`endif

  assign mem_ready = ready_q;
  assign dReadData = show_ram ? rdata : hold;

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Word-addressed data-memory responder serving the multicycle core's data port. Samples `MemRead`/`MemWrite`, `dAddress` and `dWriteData`, and performs one 32-bit access per request. After a fixed number of wait states it returns `dReadData` with a one-cycle `mem_ready` strobe. It sits between the processor top and the data RAM, and is the memory-side end of the `MemRead`/`MemWrite`/`dAddress`/`dWriteData`/`dReadData` interface.

## Interface
- `BASE_ADDR`, 32'h10010000: byte address of word 0.
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two, 16..65536.
- `WAIT_CYCLES`, 1: wait states between accept and response; legal range 0..15.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `MemRead`  in  1  read request level.
- `MemWrite`  in  1  write request level; has priority if both are high.
- `dAddress`  in  32  byte address.
- `dWriteData`  in  32  store data.
- `dReadData`  out  32  load data, registered.
- `mem_ready`  out  1  one-cycle response strobe.
- `mem_err`  out  1  access fault, valid with `mem_ready`. Constant 0 without `DMEM_ERR_CHECK_EN`.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - If `MemWrite|MemRead` is high at an edge, latch address, write data and the kind (write wins), then go to WAIT.
  - If `WAIT_CYCLES`==0, go straight to RESP instead.
- **WAIT**
  - A 4-bit counter loads `WAIT_CYCLES-1` on accept and decrements each edge.
  - Go to RESP on the edge where the count is 0.
  - Request inputs are ignored in this state.
- **RESP**
  - `mem_ready`=1 for exactly one cycle, then return to IDLE.
  - The initiator must drop its request in the cycle it sees `mem_ready`; a request still high in IDLE is accepted as a new access.
- Index = (latched address − `BASE_ADDR`) >> 2; the subtraction is 32-bit unsigned.
- **Write**
  - The array is updated on the edge entering RESP.
  - `dReadData` is unchanged by writes.
- **Read**
  - `dReadData` is loaded on the edge entering RESP and holds until the next read completes.
- Read-after-write to the same word returns the new data, with no bypass hazard, because the write has committed before the next accept.
- **Reset**
  - State goes to IDLE; `mem_ready`=0, `mem_err`=0, `dReadData`=0, counter=0.
  - Array contents are not cleared.
  - Reset in WAIT drops the pending access; no write occurs.
  - Reset in the same cycle as a request: the request is not accepted.

## Timing
- Request high at edge t (IDLE): `mem_ready` and `mem_err` are high during cycle t+1+`WAIT_CYCLES` only.
- Data is valid from that cycle on.
- Throughput: one access per `WAIT_CYCLES`+2 cycles at most; IDLE takes one cycle between accesses.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- **`DMEM_ERR_CHECK_EN` defined**
  - A fault occurs when `dAddress[1:0]`≠0 or index ≥ `DEPTH_WORDS`.
  - Faulting write: array untouched.
  - Faulting read: `dReadData` is loaded with 0.
  - `mem_err`=1 alongside `mem_ready`; timing is unchanged.
- **Not defined**
  - `dAddress[1:0]` is ignored and the index wraps modulo `DEPTH_WORDS` (low log2(`DEPTH_WORDS`) bits).
  - `mem_err` is tied to 0.

## Structure
- Package `dmem_pkg`: FSM state enum (IDLE=2'd0, WAIT=2'd1, RESP=2'd2), `WORD_W`=32, `WAIT_W`=4.
- Sub-module `dmem_array`: single-port synchronous RAM with ports clk, we, addr, wdata, rdata (registered read).
  - Instantiated once.
  - The responder FSM drives `we` and `addr` so that `rdata` is captured on the RESP entry edge.

## Test plan
- Reset then idle: `mem_ready`=0, `mem_err`=0 and `dReadData`=0 for 10 cycles with no requests.
- WAIT_CYCLES=1:
  - Write 32'hDEADBEEF @ 32'h10010008: `mem_ready` is high 2 cycles after accept.
  - Then read @ 32'h10010008 returns 32'hDEADBEEF with `mem_ready` 2 cycles after accept.
- WAIT_CYCLES=0:
  - Back-to-back reads of words 0,1,2 (preloaded 1,2,3): `mem_ready` every 2nd cycle, data 1,2,3.
  - A request held high through RESP is re-accepted.
- Both `MemRead` and `MemWrite` high with data 32'h5 @ base: a write occurs; a following read returns 5.
- Reset asserted during WAIT of a write of 32'h1234 @ base+4 (word previously 0): no `mem_ready`; a later read of base+4 returns 0.
- With `DMEM_ERR_CHECK_EN`:
  - Write @ base+2 gives `mem_err`=1 and the array is unchanged.
  - Read @ base+4*`DEPTH_WORDS` gives `mem_err`=1 and `dReadData`=0.
  - Without the macro, the same read returns word 0.
